sram_arbiter: RTL and testbench

- Shares one Sram_Operand image memory (320x240 = 76800 pixels, 8-bit) between two requesters.
- Requester 0 is the thresholding core; requester 1 is the frame loader/readback port.
- Issues at most one SRAM access per cycle, using round-robin priority with a bounded burst hold.
- Returns read data with fixed one-cycle latency and flags out-of-range addresses.

---
 rtl/sram_arbiter.sv | 80 ++++++++
 tb/tb_sram_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter sharing one pixel SRAM between two requesters.
// Grants are same-cycle, read data returns one cycle later, and out-of-range accesses set a sticky flag.
module sram_arbiter #(
  parameter int A_WIDTH   = 17,
  parameter int D_WIDTH   = 8,
  parameter int MAX_ADDR  = 76799,
  parameter int BURST_MAX = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               r0_req_i,
  input  logic               r0_rw_i,
  input  logic [A_WIDTH-1:0] r0_addr_i,
  input  logic [D_WIDTH-1:0] r0_wdata_i,
  output logic               r0_gnt_o,
  output logic               r0_rvalid_o,
  output logic [D_WIDTH-1:0] r0_rdata_o,
  input  logic               r1_req_i,
  input  logic               r1_rw_i,
  input  logic [A_WIDTH-1:0] r1_addr_i,
  input  logic [D_WIDTH-1:0] r1_wdata_i,
  output logic               r1_gnt_o,
  output logic               r1_rvalid_o,
  output logic [D_WIDTH-1:0] r1_rdata_o,
  output logic [A_WIDTH-1:0] m_addr_o,
  output logic [D_WIDTH-1:0] m_di_o,
  input  logic [D_WIDTH-1:0] m_do_i,
  output logic               m_rw_o,
  output logic               m_en_o,
  input  logic               err_clr_i,
  output logic               err_addr_o
);
  localparam int CW = $clog2(BURST_MAX + 1);
  logic          last_q, owner_q, rbad_q, err_q;
  logic [1:0]    rv_q;
  logic [CW-1:0] burst_q, burst_d;
  logic          gnt, sel, keep, rw, bad;
  logic [A_WIDTH-1:0] addr;
  logic [D_WIDTH-1:0] wd;
  // The owner keeps a contested grant only while a live burst is shorter than BURST_MAX.
  always_comb begin
    keep    = (burst_q != '0) && (burst_q < CW'(BURST_MAX));
    sel     = (r0_req_i & r1_req_i) ? (keep ? owner_q : ~last_q) : r1_req_i;
    gnt     = (r0_req_i | r1_req_i) & rst_n;
    addr    = sel ? r1_addr_i : r0_addr_i;
    wd      = sel ? r1_wdata_i : r0_wdata_i;
    rw      = sel ? r1_rw_i : r0_rw_i;
    bad     = addr > A_WIDTH'(MAX_ADDR);
    burst_d = !gnt ? '0 : (sel != owner_q || burst_q == '0) ? CW'(1) :
              (burst_q == CW'(BURST_MAX)) ? burst_q : burst_q + 1'b1;
  end
  assign r0_gnt_o    = gnt & ~sel;
  assign r1_gnt_o    = gnt & sel;
  assign m_addr_o    = gnt ? addr : '0;
  assign m_di_o      = gnt ? wd : '0;
  assign m_rw_o      = gnt & rw;
  assign m_en_o      = gnt & ~bad;
  assign r0_rvalid_o = rv_q[0];
  assign r1_rvalid_o = rv_q[1];
  assign r0_rdata_o  = (rv_q[0] & ~rbad_q) ? m_do_i : '0;
  assign r1_rdata_o  = (rv_q[1] & ~rbad_q) ? m_do_i : '0;
  assign err_addr_o  = err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      burst_q <= '0;
      rv_q    <= '0;
      rbad_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      last_q  <= gnt ? sel : last_q;
      owner_q <= gnt ? sel : owner_q;
      burst_q <= burst_d;
      rv_q    <= {gnt & sel & ~rw, gnt & ~sel & ~rw};
      rbad_q  <= bad;
      err_q   <= (gnt & bad) | (err_q & ~err_clr_i);
    end
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: randomized and directed checks of sram_arbiter against a run-length/history model.
module tb_sram_arbiter;
  localparam int MAXA = 76799;
  localparam int BMAX = 4;
  logic clk = 0, rst_n = 0, err_clr = 0;
  logic [1:0] req = 0, rw = 0, gnt, rv;
  logic [1:0][16:0] addr = '0;
  logic [1:0][7:0] wd = '0, rd;
  logic [16:0] m_addr;
  logic [7:0] m_di, m_do = 0;
  logic m_rw, m_en, err;
  logic [7:0] mem [76800];
  logic [7:0] ref_mem [76800];
  int checks = 0, errors = 0;
  int last_srv, streak, last_g;
  logic [1:0] exp_rv;
  logic [1:0][7:0] exp_rd;
  logic exp_err;

  sram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req_i(req[0]), .r0_rw_i(rw[0]), .r0_addr_i(addr[0]), .r0_wdata_i(wd[0]),
    .r0_gnt_o(gnt[0]), .r0_rvalid_o(rv[0]), .r0_rdata_o(rd[0]),
    .r1_req_i(req[1]), .r1_rw_i(rw[1]), .r1_addr_i(addr[1]), .r1_wdata_i(wd[1]),
    .r1_gnt_o(gnt[1]), .r1_rvalid_o(rv[1]), .r1_rdata_o(rd[1]),
    .m_addr_o(m_addr), .m_di_o(m_di), .m_do_i(m_do), .m_rw_o(m_rw), .m_en_o(m_en),
    .err_clr_i(err_clr), .err_addr_o(err));

  always #5 clk = ~clk;

  // SRAM: stale output is scrambled so unqualified read data cannot go unnoticed.
  always @(posedge clk) begin
    if (m_en && m_rw) mem[m_addr] <= m_di;
    else if (m_en) m_do <= mem[m_addr];
    else m_do <= 8'($urandom);
  end

  function automatic int exp_sel();
    if (!rst_n) return -1;
    if (req[0] && req[1]) return (streak > 0 && streak < BMAX) ? last_srv : 1 - last_srv;
    if (req[0]) return 0;
    if (req[1]) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    last_srv = 1; streak = 0; last_g = -1;
    exp_rv = 0; exp_rd = '0; exp_err = 0;
  endtask

  task automatic adv();
    int g;
    logic bad;
    @(posedge clk);
    g = exp_sel();
    exp_rv = 0; exp_rd = '0;
    if (g >= 0) begin
      bad = int'(addr[g]) > MAXA;
      if (!rw[g]) begin
        exp_rv[g] = 1;
        exp_rd[g] = bad ? 8'h00 : ref_mem[addr[g]];
      end else if (!bad) ref_mem[addr[g]] = wd[g];
      streak = (g == last_srv && streak > 0) ? ((streak < BMAX) ? streak + 1 : BMAX) : 1;
      last_srv = g;
      exp_err = bad || (exp_err && !err_clr);
    end else begin
      streak = 0;
      exp_err = exp_err && !err_clr;
    end
    last_g = g;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0; req = 0; err_clr = 0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_reset();
    req = 2'b01; rw = 0; addr[0] = 17'd5;
    #1;
    checks++;
    if (gnt !== 2'b00 || m_en !== 0 || m_rw !== 0 || m_addr !== 0 || m_di !== 0) begin
      errors++; $display("FAIL reset_cmd gnt=%b en=%b rw=%b addr=%0d di=%0h want all 0", gnt, m_en, m_rw, m_addr, m_di);
    end
    checks++;
    if (rv !== 2'b00 || rd !== '0 || err !== 0) begin
      errors++; $display("FAIL reset_ret rv=%b rd=%h err=%b want 0", rv, rd, err);
    end
    do_reset();
  endtask

  task automatic test_single_read();
    req = 2'b01; rw = 2'b00; addr[0] = 0;
    @(negedge clk);
    checks++;
    if (gnt !== 2'b01 || m_en !== 1 || m_rw !== 0 || m_addr !== 0) begin
      errors++; $display("FAIL single_cmd gnt=%b en=%b rw=%b addr=%0d want 01 1 0 0", gnt, m_en, m_rw, m_addr);
    end
    adv();
    req = 0;
    @(negedge clk);
    checks++;
    if (rv !== 2'b01 || rd[0] !== ref_mem[0] || rd[1] !== 0) begin
      errors++; $display("FAIL single_ret rv=%b rd0=%h rd1=%h want 01 %h 00", rv, rd[0], rd[1], ref_mem[0]);
    end
    adv();
  endtask

  task automatic test_round_robin();
    logic [1:0] want;
    do_reset();
    req = 2'b11; rw = 2'b00;
    for (int i = 0; i < 12; i++) begin
      addr[0] = 17'($urandom_range(0, MAXA)); addr[1] = 17'($urandom_range(0, MAXA));
      want = ((i / 4) % 2 == 1) ? 2'b10 : 2'b01;
      @(negedge clk);
      checks++;
      if (gnt !== want) begin
        errors++; $display("FAIL rr_gnt cycle=%0d gnt=%b want %b", i, gnt, want);
      end
      if (i > 0) begin
        checks++;
        if (rv !== exp_rv || rd !== exp_rd) begin
          errors++; $display("FAIL rr_ret cycle=%0d rv=%b rd=%h want %b %h", i, rv, rd, exp_rv, exp_rd);
        end
      end
      adv();
    end
    req = 0;
    adv();
  endtask

  task automatic test_boundary();
    req = 2'b10; rw = 2'b10; addr[1] = 17'(MAXA); wd[1] = 8'hA5;
    @(negedge clk);
    checks++;
    if (gnt !== 2'b10 || m_en !== 1 || m_rw !== 1 || m_addr !== 17'(MAXA) || m_di !== 8'hA5) begin
      errors++; $display("FAIL edge_wr gnt=%b en=%b rw=%b addr=%0d di=%h", gnt, m_en, m_rw, m_addr, m_di);
    end
    adv();
    req = 2'b01; rw = 2'b00; addr[0] = 17'(MAXA);
    @(negedge clk);
    checks++;
    if (gnt !== 2'b01 || m_en !== 1 || m_addr !== 17'(MAXA)) begin
      errors++; $display("FAIL edge_rd gnt=%b en=%b addr=%0d want 01 1 %0d", gnt, m_en, m_addr, MAXA);
    end
    adv();
    req = 0;
    @(negedge clk);
    checks++;
    if (rv !== 2'b01 || rd[0] !== 8'hA5 || err !== 0) begin
      errors++; $display("FAIL edge_data rv=%b rd0=%h err=%b want 01 a5 0", rv, rd[0], err);
    end
    adv();
  endtask

  task automatic test_error();
    req = 2'b01; rw = 2'b00; addr[0] = 17'(MAXA + 1);
    @(negedge clk);
    checks++;
    if (gnt !== 2'b01 || m_en !== 0) begin
      errors++; $display("FAIL oor_cmd gnt=%b en=%b want 01 0", gnt, m_en);
    end
    adv();
    req = 0;
    @(negedge clk);
    checks++;
    if (rv !== 2'b01 || rd[0] !== 0 || err !== 1) begin
      errors++; $display("FAIL oor_ret rv=%b rd0=%h err=%b want 01 00 1", rv, rd[0], err);
    end
    err_clr = 1;
    adv();
    err_clr = 0;
    @(negedge clk);
    checks++;
    if (err !== 0) begin
      errors++; $display("FAIL err_clear err=%b want 0", err);
    end
    err_clr = 1; req = 2'b10; rw = 2'b10; addr[1] = 17'd100000; wd[1] = 8'h3C;
    adv();
    err_clr = 0; req = 0;
    @(negedge clk);
    checks++;
    if (err !== 1 || rv !== 0) begin
      errors++; $display("FAIL err_set_wins err=%b rv=%b want 1 00", err, rv);
    end
    err_clr = 1;
    adv();
    err_clr = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 2'b11; rw = 2'b00; addr[0] = 17'd1234; addr[1] = 17'd4321;
    adv();
    adv();
    #1;
    rst_n = 0;
    #1;
    checks++;
    if (gnt !== 0 || rv !== 0 || rd !== '0 || m_en !== 0 || m_addr !== 0 || err !== 0) begin
      errors++; $display("FAIL mid_reset gnt=%b rv=%b rd=%h en=%b addr=%0d err=%b want 0", gnt, rv, rd, m_en, m_addr, err);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    #1;
    checks++;
    if (rv !== 0 || gnt !== 2'b01) begin
      errors++; $display("FAIL post_reset rv=%b gnt=%b want 00 01", rv, gnt);
    end
    adv();
    req = 0;
    @(negedge clk);
    checks++;
    if (rv !== 2'b01 || rd[0] !== ref_mem[1234]) begin
      errors++; $display("FAIL post_reset_rd rv=%b rd0=%h want 01 %h", rv, rd[0], ref_mem[1234]);
    end
    adv();
  endtask

  task automatic test_random();
    int g;
    logic [1:0] want_g;
    for (int i = 0; i < 2000; i++) begin
      for (int x = 0; x < 2; x++) begin
        if (!req[x] || last_g == x) begin
          req[x] = $urandom_range(0, 3) != 0;
          rw[x] = $urandom_range(0, 1) == 1;
          addr[x] = ($urandom_range(0, 19) == 0) ? 17'(MAXA + 1 + $urandom_range(0, 5000)) : 17'($urandom_range(0, MAXA));
          wd[x] = 8'($urandom);
        end
      end
      err_clr = $urandom_range(0, 7) == 0;
      g = exp_sel();
      want_g = (g < 0) ? 2'b00 : (g == 0) ? 2'b01 : 2'b10;
      @(negedge clk);
      checks++;
      if (gnt !== want_g) begin
        errors++; $display("FAIL rnd_gnt i=%0d gnt=%b want %b", i, gnt, want_g);
      end
      checks++;
      if (g >= 0 && (m_addr !== addr[g] || m_rw !== rw[g] || m_di !== wd[g] || m_en !== (int'(addr[g]) <= MAXA))) begin
        errors++; $display("FAIL rnd_cmd i=%0d addr=%0d rw=%b di=%h en=%b want %0d %b %h", i, m_addr, m_rw, m_di, m_en, addr[g], rw[g], wd[g]);
      end else if (g < 0 && (m_en !== 0 || m_rw !== 0 || m_addr !== 0 || m_di !== 0)) begin
        errors++; $display("FAIL rnd_idle i=%0d en=%b rw=%b addr=%0d di=%h want 0", i, m_en, m_rw, m_addr, m_di);
      end
      checks++;
      if (rv !== exp_rv || rd !== exp_rd || err !== exp_err) begin
        errors++; $display("FAIL rnd_ret i=%0d rv=%b rd=%h err=%b want %b %h %b", i, rv, rd, err, exp_rv, exp_rd, exp_err);
      end
      adv();
    end
    req = 0; err_clr = 1;
    adv();
    err_clr = 0;
  endtask

  task automatic test_frame();
    int good = 0, bad = 0;
    req = 2'b10; rw = 2'b10;
    for (int k = 0; k <= 4800; k++) begin
      addr[1] = (k < 4800) ? 17'(k * 16) : 17'(MAXA);
      wd[1] = 8'($urandom);
      adv();
    end
    rw = 2'b00;
    for (int k = 0; k <= 4801; k++) begin
      req = (k <= 4800) ? 2'b10 : 2'b00;
      addr[1] = (k < 4800) ? 17'(k * 16) : 17'(MAXA);
      @(negedge clk);
      if (k > 0) begin
        checks++;
        if (rv !== 2'b10 || rd[1] !== exp_rd[1]) begin
          errors++; bad++;
          $display("FAIL frame_rd k=%0d rv=%b rd1=%h want 10 %h", k - 1, rv, rd[1], exp_rd[1]);
        end else good++;
      end
      adv();
    end
    checks++;
    if (err !== 0) begin
      errors++; $display("FAIL frame_err err=%b want 0", err);
    end
    $display("frame readback: %0d correct, %0d incorrect", good, bad);
  endtask

  initial begin
    for (int i = 0; i < 76800; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    model_reset();
    test_reset();
    test_single_read();
    test_round_robin();
    test_boundary();
    test_error();
    test_reset_mid();
    test_random();
    test_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
